// File: rtl/module_program_loader_if.sv
// Byte-stream and instruction-memory write port bundle for module_program_loader.
// master: host/debug byte source side. slave: the loader itself.
interface module_program_loader_if #(
   parameter int WORD_SIZE    = 32,
   parameter int ADDRESS_BITS = 32
);
   logic                    start;
   logic [ADDRESS_BITS-1:0] length;
   logic                    byte_valid;
   logic [7:0]              byte_data;
   logic                    byte_ready;
   logic                    imem_wr_en;
   logic [ADDRESS_BITS-1:0] imem_addr;
   logic [WORD_SIZE-1:0]    imem_code;
   logic                    cpu_hold;
   logic                    done;
   logic                    err;

   modport master (
      output start, length, byte_valid, byte_data,
      input  byte_ready, imem_wr_en, imem_addr, imem_code, cpu_hold, done, err
   );

   modport slave (
      input  start, length, byte_valid, byte_data,
      output byte_ready, imem_wr_en, imem_addr, imem_code, cpu_hold, done, err
   );
endinterface

// File: rtl/module_program_loader.sv
// Program loader: assembles a little-endian byte stream into instruction words
// and writes them to consecutive instruction-memory addresses while holding
// the CPU off. Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
module module_program_loader #(
   parameter int WORD_SIZE    = 32,
   parameter int ADDRESS_BITS = 32,
   parameter int MEMORY       = 1024
) (
   input logic                   clk,
   input logic                   rst_n,
   module_program_loader_if.slave bus
);
   localparam int BPW   = WORD_SIZE / 8;
   localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(BPW - 1);
   localparam logic [ADDRESS_BITS-1:0] MEM_WORDS = ADDRESS_BITS'(MEMORY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
`ifdef LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDRESS_BITS-1:0] length_q, length_d;
   logic [ADDRESS_BITS-1:0] addr_q, addr_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [WORD_SIZE-1:0]    code_q, code_d;
   logic                    err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]              sum_q, sum_d;
   logic [7:0]              check_total;

   assign check_total = sum_q + bus.byte_data;
`endif

   // Register all loader state; reset discards any partially assembled word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         length_q <= '0;
         addr_q   <= '0;
         idx_q    <= '0;
         code_q   <= '0;
         err_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         length_q <= length_d;
         addr_q   <= addr_d;
         idx_q    <= idx_d;
         code_q   <= code_d;
         err_q    <= err_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q    <= sum_d;
`endif
      end
   end

   // Next-state logic: accept a load, gather bytes, write words, finish.
   always_comb begin
      state_d  = state_q;
      length_d = length_q;
      addr_d   = addr_q;
      idx_d    = idx_q;
      code_d   = code_q;
      err_d    = err_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d    = sum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.length > MEM_WORDS) begin
                  err_d = 1'b1;
               end else begin
                  length_d = bus.length;
                  err_d    = 1'b0;
                  addr_d   = '0;
                  idx_d    = '0;
`ifdef LOADER_CHECKSUM_EN
                  sum_d    = '0;
`endif
                  state_d  = (bus.length == '0) ? S_DONE : S_RECV;
               end
            end
         end
         S_RECV: begin
            if (bus.byte_valid) begin
               code_d[8*idx_q +: 8] = bus.byte_data;
`ifdef LOADER_CHECKSUM_EN
               sum_d = sum_q + bus.byte_data;
`endif
               if (idx_q == LAST_IDX) begin
                  state_d = S_WRITE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (addr_q == length_q - 1'b1) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_DONE;
`endif
            end else begin
               addr_d  = addr_q + 1'b1;
               idx_d   = '0;
               state_d = S_RECV;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (bus.byte_valid) begin
               if (check_total != 8'h00) begin
                  err_d = 1'b1;
               end
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are flops or pure state decodes, never combinational from inputs.
`ifdef LOADER_CHECKSUM_EN
   assign bus.byte_ready = (state_q == S_RECV) || (state_q == S_CHECK);
`else
   assign bus.byte_ready = (state_q == S_RECV);
`endif
   assign bus.imem_wr_en = (state_q == S_WRITE);
   assign bus.imem_addr  = addr_q;
   assign bus.imem_code  = code_q;
   assign bus.cpu_hold   = (state_q != S_IDLE);
   assign bus.done       = (state_q == S_DONE) && !err_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_module_program_loader.sv
// Directed self-checking bench for module_program_loader.
// Build with LOADER_CHECKSUM_EN defined to also exercise the checksum byte.
`timescale 1ns/1ps
module tb_module_program_loader;
   localparam int WORD_SIZE    = 32;
   localparam int ADDRESS_BITS = 32;
   localparam int MEMORY       = 1024;
`ifdef LOADER_CHECKSUM_EN
   localparam int CK_CYCLES = 1;
`else
   localparam int CK_CYCLES = 0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int errors = 0;
   int checks = 0;
   logic [7:0] run_sum = 8'h00;

   int wr_count       = 0;
   int hold_cycles    = 0;
   int done_pulses    = 0;
   int ready_in_write = 0;
   logic [ADDRESS_BITS-1:0] wr_addr_q[$];
   logic [WORD_SIZE-1:0]    wr_code_q[$];

   module_program_loader_if #(.WORD_SIZE(WORD_SIZE), .ADDRESS_BITS(ADDRESS_BITS)) bus ();

   module_program_loader #(
      .WORD_SIZE(WORD_SIZE),
      .ADDRESS_BITS(ADDRESS_BITS),
      .MEMORY(MEMORY)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Record memory writes and per-cycle status mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (bus.imem_wr_en === 1'b1) begin
         wr_count++;
         wr_addr_q.push_back(bus.imem_addr);
         wr_code_q.push_back(bus.imem_code);
         if (bus.byte_ready === 1'b1) ready_in_write++;
      end
      if (bus.cpu_hold === 1'b1) hold_cycles++;
      if (bus.done === 1'b1) done_pulses++;
   end

   // Hard stop in case the sequence below ever stalls.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
      checkOutput({tag, "_wr_en"},      64'(bus.imem_wr_en), 64'd0);
      checkOutput({tag, "_addr"},       64'(bus.imem_addr),  64'd0);
      checkOutput({tag, "_code"},       64'(bus.imem_code),  64'd0);
      checkOutput({tag, "_cpu_hold"},   64'(bus.cpu_hold),   64'd0);
      checkOutput({tag, "_done"},       64'(bus.done),       64'd0);
      checkOutput({tag, "_err"},        64'(bus.err),        64'd0);
   endtask

   // One-cycle start request; leaves the bench #1 after the accepting edge.
   task automatic applyStimulus(input logic [ADDRESS_BITS-1:0] len);
      bus.start  = 1'b1;
      bus.length = len;
      run_sum    = 8'h00;
      tick(1);
      bus.start  = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b, input bit gap);
      int waited = 0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      @(negedge clk);
      while (bus.byte_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (bus.byte_ready !== 1'b1) checkOutput("byte_accept_timeout", 64'(bus.byte_ready), 64'd1);
      @(posedge clk);
      #1;
      run_sum = run_sum + b;
      if (gap) begin
         bus.byte_valid = 1'b0;
         tick(1);
      end
   endtask

   task automatic sendWord(input logic [31:0] w, input bit gap);
      for (int k = 0; k < 4; k++) sendByte(w[8*k +: 8], gap);
   endtask

   // Appends the balancing checksum byte when the checksum feature is built in.
   task automatic sendChecksum();
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] ck;
      ck = 8'h00 - run_sum;
      sendByte(ck, 1'b0);
`endif
      bus.byte_valid = 1'b0;
   endtask

   initial begin
      int base_wr;
      int base_hold;
      int base_done;
      int addr_bad;
      logic [31:0] w;

      bus.start      = 1'b0;
      bus.length     = '0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;

      // Reset state, then five idle cycles after release.
      #3;
      checkIdle("reset");
      #9;
      rst_n = 1'b1;
      tick(5);
      checkIdle("post_reset_idle");

      // Basic two-word load with byte_valid held high.
      base_wr = wr_count; base_hold = hold_cycles; base_done = done_pulses;
      applyStimulus(2);
      sendWord(32'h12345678, 1'b0);
      sendWord(32'hDEADBEEF, 1'b0);
      sendChecksum();
      tick(4);
      checkOutput("basic_wr_count", 64'(wr_count - base_wr), 64'd2);
      checkOutput("basic_addr0", 64'(wr_addr_q[base_wr]), 64'd0);
      checkOutput("basic_code0", 64'(wr_code_q[base_wr]), 64'h12345678);
      checkOutput("basic_addr1", 64'(wr_addr_q[base_wr+1]), 64'd1);
      checkOutput("basic_code1", 64'(wr_code_q[base_wr+1]), 64'hDEADBEEF);
      checkOutput("basic_done_pulses", 64'(done_pulses - base_done), 64'd1);
      checkOutput("basic_hold_cycles", 64'(hold_cycles - base_hold), 64'(11 + CK_CYCLES));
      checkOutput("basic_err", 64'(bus.err), 64'd0);
      checkOutput("basic_hold_released", 64'(bus.cpu_hold), 64'd0);

      // Same stream with a one-cycle gap after every byte.
      base_wr = wr_count; base_done = done_pulses;
      applyStimulus(2);
      sendWord(32'h12345678, 1'b1);
      sendWord(32'hDEADBEEF, 1'b1);
      sendChecksum();
      tick(4);
      checkOutput("gap_wr_count", 64'(wr_count - base_wr), 64'd2);
      checkOutput("gap_addr0", 64'(wr_addr_q[base_wr]), 64'd0);
      checkOutput("gap_code0", 64'(wr_code_q[base_wr]), 64'h12345678);
      checkOutput("gap_addr1", 64'(wr_addr_q[base_wr+1]), 64'd1);
      checkOutput("gap_code1", 64'(wr_code_q[base_wr+1]), 64'hDEADBEEF);
      checkOutput("gap_done_pulses", 64'(done_pulses - base_done), 64'd1);
      checkOutput("ready_never_in_write", 64'(ready_in_write), 64'd0);

      // Zero-length load: done one cycle after start, nothing written.
      base_wr = wr_count;
      applyStimulus(0);
      checkOutput("len0_done", 64'(bus.done), 64'd1);
      checkOutput("len0_hold", 64'(bus.cpu_hold), 64'd1);
      tick(1);
      checkOutput("len0_done_after", 64'(bus.done), 64'd0);
      checkOutput("len0_hold_after", 64'(bus.cpu_hold), 64'd0);
      checkOutput("len0_wr_count", 64'(wr_count - base_wr), 64'd0);

      // Oversized load is refused with a sticky error.
      base_wr = wr_count; base_hold = hold_cycles;
      applyStimulus(1025);
      checkOutput("len1025_err", 64'(bus.err), 64'd1);
      checkOutput("len1025_hold", 64'(bus.cpu_hold), 64'd0);
      tick(2);
      checkOutput("len1025_err_sticky", 64'(bus.err), 64'd1);
      checkOutput("len1025_wr_count", 64'(wr_count - base_wr), 64'd0);
      checkOutput("len1025_hold_cycles", 64'(hold_cycles - base_hold), 64'd0);

      // Full-depth load; byte value is the running byte index modulo 256.
      base_wr = wr_count; base_done = done_pulses;
      applyStimulus(1024);
      checkOutput("len1024_err_cleared", 64'(bus.err), 64'd0);
      for (int i = 0; i < 1024; i++) begin
         for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'((i * 4 + k) & 8'hFF);
         sendWord(w, 1'b0);
      end
      sendChecksum();
      tick(3);
      addr_bad = 0;
      for (int i = 0; i < 1024; i++) begin
         if (wr_addr_q[base_wr+i] !== 32'(i)) addr_bad++;
      end
      checkOutput("len1024_wr_count", 64'(wr_count - base_wr), 64'd1024);
      checkOutput("len1024_addr_sequence", 64'(addr_bad), 64'd0);
      checkOutput("len1024_code0", 64'(wr_code_q[base_wr]), 64'h03020100);
      checkOutput("len1024_last_addr", 64'(wr_addr_q[base_wr+1023]), 64'd1023);
      checkOutput("len1024_last_code", 64'(wr_code_q[base_wr+1023]), 64'hFFFEFDFC);
      checkOutput("len1024_done_pulses", 64'(done_pulses - base_done), 64'd1);

      // Reset in the middle of word 1; outputs drop without waiting for a clock.
      base_wr = wr_count;
      applyStimulus(2);
      sendWord(32'hCAFEF00D, 1'b0);
      sendByte(8'hAA, 1'b0);
      sendByte(8'hBB, 1'b0);
      bus.byte_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkIdle("abort");
      checkOutput("abort_wr_count", 64'(wr_count - base_wr), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      base_wr = wr_count; base_done = done_pulses;
      applyStimulus(1);
      sendWord(32'h44332211, 1'b0);
      sendChecksum();
      tick(3);
      checkOutput("reload_wr_count", 64'(wr_count - base_wr), 64'd1);
      checkOutput("reload_addr", 64'(wr_addr_q[base_wr]), 64'd0);
      checkOutput("reload_code", 64'(wr_code_q[base_wr]), 64'h44332211);
      checkOutput("reload_done_pulses", 64'(done_pulses - base_done), 64'd1);

`ifdef LOADER_CHECKSUM_EN
      // Good checksum: 01+02+03+04+F6 wraps to zero.
      base_done = done_pulses;
      applyStimulus(1);
      sendWord(32'h04030201, 1'b0);
      sendByte(8'hF6, 1'b0);
      bus.byte_valid = 1'b0;
      tick(3);
      checkOutput("ck_good_done", 64'(done_pulses - base_done), 64'd1);
      checkOutput("ck_good_err", 64'(bus.err), 64'd0);

      // Bad checksum: off by one, error set and done suppressed.
      base_done = done_pulses;
      applyStimulus(1);
      sendWord(32'h04030201, 1'b0);
      sendByte(8'hF7, 1'b0);
      bus.byte_valid = 1'b0;
      tick(3);
      checkOutput("ck_bad_done", 64'(done_pulses - base_done), 64'd0);
      checkOutput("ck_bad_err", 64'(bus.err), 64'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
